// File: rtl/accumulator_bank_pkg.sv
// accumulator_bank_pkg: shared defaults and tap index constants for the correlator accumulator bank
`ifndef INPUT_WIDTH
`define INPUT_WIDTH 3
`endif
package accumulator_bank_pkg;
  localparam int TAP_EARLY  = 0;
  localparam int TAP_PROMPT = 1;
  localparam int TAP_LATE   = 2;
  localparam int DEF_TAPS   = TAP_LATE + 1;
endpackage

// File: rtl/accumulator_tap.sv
// accumulator_tap: one lane of code wipe-off, stage-1 register and coherent accumulator (ACC_SATURATE_EN selects clamping)
import accumulator_bank_pkg::*;
module accumulator_tap #(
  parameter int INPUT_WIDTH  = `INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_valid,
  input  logic                    s1_valid,
  input  logic                    s1_epoch,
  input  logic [INPUT_WIDTH-1:0]  baseband_input,
  input  logic                    ca_bit,
  output logic [OUTPUT_WIDTH-1:0] acc,
  output logic                    overflow
);
  logic [OUTPUT_WIDTH-1:0] mag, value_d, value_q, sum, add_res, acc_d, acc_q;
  logic                    wsign, add_ovf, ovf_d, ovf_q;
  // wipe-off, sign-magnitude to two's complement, overflow-checked add and epoch reload
  always_comb begin
    mag     = OUTPUT_WIDTH'(baseband_input[INPUT_WIDTH-2:0]);
    wsign   = baseband_input[INPUT_WIDTH-1] ^ ~ca_bit;
    value_d = wsign ? -mag : mag;
    sum     = acc_q + value_q;
    add_ovf = (acc_q[OUTPUT_WIDTH-1] == value_q[OUTPUT_WIDTH-1]) && (sum[OUTPUT_WIDTH-1] != acc_q[OUTPUT_WIDTH-1]);
`ifdef ACC_SATURATE_EN
    add_res = !add_ovf ? sum : acc_q[OUTPUT_WIDTH-1] ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}} : {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
`else
    add_res = sum;
`endif
    acc_d   = !s1_valid ? acc_q : s1_epoch ? value_q : add_res;
    ovf_d   = !s1_valid ? ovf_q : s1_epoch ? 1'b0 : (ovf_q | add_ovf);
  end
  // stage-1 value capture and stage-2 accumulator state
  always_ff @(posedge clk) begin
    if (!reset) begin
      value_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (sample_valid) value_q <= value_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end
  assign acc      = acc_q;
  assign overflow = ovf_q;
endmodule

// File: rtl/accumulator_bank.sv
// accumulator_bank: multi-tap coherent accumulator with self-timed epoch dumps (optional ACC_SATURATE_EN clamps tap sums)
import accumulator_bank_pkg::*;
module accumulator_bank #(
  parameter int INPUT_WIDTH  = `INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = 16,
  parameter int NUM_TAPS     = DEF_TAPS,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             sample_valid,
  input  logic                             epoch,
  input  logic [INPUT_WIDTH-1:0]           baseband_input,
  input  logic [NUM_TAPS-1:0]              ca_bits,
  output logic                             dump_valid,
  output logic [NUM_TAPS*OUTPUT_WIDTH-1:0] dump_acc,
  output logic [COUNT_WIDTH-1:0]           dump_count,
  output logic [NUM_TAPS-1:0]              dump_overflow
);
  logic                             s1_valid_q, s1_epoch_q, primed_q, primed_d, req_q, req_d, dump_valid_q;
  logic [COUNT_WIDTH-1:0]           count_q, count_d, snap_count_q, dump_count_q;
  logic [NUM_TAPS*OUTPUT_WIDTH-1:0] acc_w, snap_acc_q, dump_acc_q;
  logic [NUM_TAPS-1:0]              ovf_w, snap_ovf_q, dump_ovf_q;
  genvar i;
  generate
    for (i = 0; i < NUM_TAPS; i++) begin : g_tap
      accumulator_tap #(.INPUT_WIDTH(INPUT_WIDTH), .OUTPUT_WIDTH(OUTPUT_WIDTH)) u_tap (
        .clk            (clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .s1_valid       (s1_valid_q),
        .s1_epoch       (s1_epoch_q),
        .baseband_input (baseband_input),
        .ca_bit         (ca_bits[i]),
        .acc            (acc_w[i*OUTPUT_WIDTH +: OUTPUT_WIDTH]),
        .overflow       (ovf_w[i])
      );
    end
  endgenerate
  // sample counter, priming and dump request decisions for the stage-2 sample
  always_comb begin
    req_d    = s1_valid_q & s1_epoch_q & primed_q;
    primed_d = primed_q | (s1_valid_q & s1_epoch_q);
    count_d  = !s1_valid_q ? count_q : s1_epoch_q ? COUNT_WIDTH'(1) : &count_q ? count_q : count_q + COUNT_WIDTH'(1);
  end
  // epoch pipeline, counter and snapshot of the closing period taken before the taps reload
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q   <= 1'b0;
      s1_epoch_q   <= 1'b0;
      count_q      <= '0;
      primed_q     <= 1'b0;
      req_q        <= 1'b0;
      snap_acc_q   <= '0;
      snap_count_q <= '0;
      snap_ovf_q   <= '0;
    end else begin
      s1_valid_q <= sample_valid;
      s1_epoch_q <= sample_valid & epoch;
      count_q    <= count_d;
      primed_q   <= primed_d;
      req_q      <= req_d;
      if (req_d) begin
        snap_acc_q   <= acc_w;
        snap_count_q <= count_q;
        snap_ovf_q   <= ovf_w;
      end
    end
  end
  // dump registers: one-cycle strobe, data held until the next dump
  always_ff @(posedge clk) begin
    if (!reset) begin
      dump_valid_q <= 1'b0;
      dump_acc_q   <= '0;
      dump_count_q <= '0;
      dump_ovf_q   <= '0;
    end else begin
      dump_valid_q <= req_q;
      if (req_q) begin
        dump_acc_q   <= snap_acc_q;
        dump_count_q <= snap_count_q;
        dump_ovf_q   <= snap_ovf_q;
      end
    end
  end
  assign dump_valid    = dump_valid_q;
  assign dump_acc      = dump_acc_q;
  assign dump_count    = dump_count_q;
  assign dump_overflow = dump_ovf_q;
endmodule
